seg7_scan_driver: RTL and testbench

- Parametrised multiplexed seven-segment display driver; next generation of the team's 3-to-8 active-low anode decoder.
- Scans NUM_DIGITS common-anode digits using an internal refresh prescaler, and decodes per-digit 4-bit hex values to active-low segments.
- Adds per-digit blanking, decimal points, anode guard (dead) time against ghosting, and tear-free frame-synchronous input latching.
- Sits between the datapath/register file and the board's anode/segment pins.

---
 rtl/seg7_scan_driver_if.sv | 27 ++
 rtl/seg7_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display bus between a datapath and the seven-segment scan driver.
// master: drives en/digits_i/dp_i/blank_i; slave: drives an_o/seg_o/dp_o/idx_o/frame_tick_o.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic                    en;
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic [NUM_DIGITS-1:0]   an_o;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [IDX_W-1:0]        idx_o;
    logic                    frame_tick_o;

    modport master (
        output en, digits_i, dp_i, blank_i,
        input  an_o, seg_o, dp_o, idx_o, frame_tick_o
    );

    modport slave (
        input  en, digits_i, dp_i, blank_i,
        output an_o, seg_o, dp_o, idx_o, frame_tick_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver: refresh prescaler, digit
// scan with anode guard time, frame-synchronous shadow latch, hex decode.
// Ports: clk, rst_n (sync, active low), bus (slave side of seg7_scan_driver_if):
//   en, digits_i, dp_i, blank_i in; an_o, seg_o, dp_o, idx_o, frame_tick_o out.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int IDX_W       = $clog2(NUM_DIGITS)
) (
    input logic                clk,
    input logic                rst_n,
    seg7_scan_driver_if.slave  bus
);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]                 pre_q, pre_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]       sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]            sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]            sh_blank_q, sh_blank_d;
    logic                             load_pend_q, load_pend_d;
    logic [NUM_DIGITS-1:0]            an_q, an_d;
    logic [6:0]                       seg_q, seg_d;
    logic                             dp_q, dp_d;
    logic                             tick_q, tick_d;

    logic slot_end;
    logic wrap;
    logic guard_ok;
    logic lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        pre_d       = pre_q;
        idx_d       = idx_q;
        sh_dig_d    = sh_dig_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        load_pend_d = load_pend_q;
        an_d        = '1;
        seg_d       = 7'h7F;
        dp_d        = 1'b1;
        tick_d      = 1'b0;

        slot_end = (pre_q == PRE_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
        // Dead time at slot start keeps the previous digit from ghosting.
        guard_ok = (GUARD == 0) || (pre_q >= PRE_GUARD);
        lit      = guard_ok && !sh_blank_q[idx_q];

        if (bus.en) begin
            pre_d  = slot_end ? '0 : pre_q + PRE_W'(1);
            tick_d = wrap;
            if (slot_end) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            if (lit) begin
                an_d  = ~(NUM_DIGITS'(1) << idx_q);
                seg_d = hex7(sh_dig_q[idx_q]);
                dp_d  = ~sh_dp_q[idx_q];
            end
            // Latch only at frame boundary so a frame never mixes old/new data.
            if (wrap || load_pend_q) begin
                sh_dig_d    = bus.digits_i;
                sh_dp_d     = bus.dp_i;
                sh_blank_d  = bus.blank_i;
                load_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q       <= '0;
            idx_q       <= '0;
            sh_dig_q    <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            load_pend_q <= 1'b1;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            sh_dig_q    <= sh_dig_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            load_pend_q <= load_pend_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.an_o         = an_q;
    assign bus.seg_o        = seg_q;
    assign bus.dp_o         = dp_q;
    assign bus.idx_o        = idx_q;
    assign bus.frame_tick_o = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: 4-digit and 5-digit instances
// (REFRESH_DIV=8, GUARD=2) driven in lockstep against a behavioural model.
module tb_seg7_scan_driver;
    localparam int DIV = 8;
    localparam int GRD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [63:0] t_dig;
    logic [15:0] t_dp;
    logic [15:0] t_blank;

    int n_assert = 0;
    int n_fail   = 0;
    int ticks4   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) b4 ();
    seg7_scan_driver_if #(.NUM_DIGITS(5)) b5 ();

    assign b4.en       = en;
    assign b4.digits_i = t_dig[15:0];
    assign b4.dp_i     = t_dp[3:0];
    assign b4.blank_i  = t_blank[3:0];
    assign b5.en       = en;
    assign b5.digits_i = t_dig[19:0];
    assign b5.dp_i     = t_dp[4:0];
    assign b5.blank_i  = t_blank[4:0];

    seg7_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(DIV), .GUARD(GRD)
    ) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(5), .REFRESH_DIV(DIV), .GUARD(GRD)
    ) u5 (
        .clk(clk), .rst_n(rst_n), .bus(b5.slave)
    );

    typedef struct {
        int          pre;
        int          idx;
        logic [63:0] dig;
        logic [15:0] dp;
        logic [15:0] blank;
        bit          lp;
    } model_t;

    typedef struct {
        logic [15:0] an;
        logic [6:0]  seg;
        logic        dp;
        logic        tick;
        int          idx;
    } exp_t;

    logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    model_t m4, m5;
    exp_t   q4 [$];
    exp_t   q5 [$];

    function automatic void mstep(input model_t mi, input int nd,
                                  output model_t mo, output exp_t e);
        logic [15:0] ones;
        bit          lit;
        bit          wrap;
        ones = 16'((32'd1 << nd) - 1);
        mo   = mi;
        e.an   = ones;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.tick = 1'b0;
        if (!rst_n) begin
            mo.pre   = 0;
            mo.idx   = 0;
            mo.dig   = '0;
            mo.dp    = '0;
            mo.blank = '1;
            mo.lp    = 1'b1;
        end else if (en) begin
            lit  = (mi.pre >= GRD) && !mi.blank[mi.idx];
            wrap = (mi.pre == DIV - 1) && (mi.idx == nd - 1);
            if (lit) begin
                e.an  = ones & ~(16'd1 << mi.idx);
                e.seg = HEX[mi.dig[mi.idx*4 +: 4]];
                e.dp  = ~mi.dp[mi.idx];
            end
            e.tick = wrap;
            if (mi.pre == DIV - 1) begin
                mo.pre = 0;
                mo.idx = (mi.idx == nd - 1) ? 0 : mi.idx + 1;
            end else begin
                mo.pre = mi.pre + 1;
            end
            if (wrap || mi.lp) begin
                mo.dig   = t_dig;
                mo.dp    = t_dp;
                mo.blank = t_blank;
                mo.lp    = 1'b0;
            end
        end
        e.idx = mo.idx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t   e4, e5, p4, p5;
        model_t n4, n5;
        mstep(m4, 4, n4, e4);
        mstep(m5, 5, n5, e5);
        m4 = n4;
        m5 = n5;
        q4.push_back(e4);
        q5.push_back(e5);
        @(posedge clk);
        #1;
        p4 = q4.pop_front();
        p5 = q5.pop_front();
        chk("an4",   32'(b4.an_o), 32'(p4.an));
        chk("seg4",  32'(b4.seg_o), 32'(p4.seg));
        chk("dp4",   32'(b4.dp_o), 32'(p4.dp));
        chk("tick4", 32'(b4.frame_tick_o), 32'(p4.tick));
        chk("idx4",  32'(b4.idx_o), 32'(p4.idx));
        chk("an5",   32'(b5.an_o), 32'(p5.an));
        chk("seg5",  32'(b5.seg_o), 32'(p5.seg));
        chk("dp5",   32'(b5.dp_o), 32'(p5.dp));
        chk("tick5", 32'(b5.frame_tick_o), 32'(p5.tick));
        chk("idx5",  32'(b5.idx_o), 32'(p5.idx));
        chk("an4_1hot", 32'($countones(~b4.an_o) <= 1), 32'd1);
        chk("an5_1hot", 32'($countones(~b5.an_o) <= 1), 32'd1);
        if (b4.frame_tick_o) ticks4++;
    endtask

    initial begin
        m4 = '{pre: 0, idx: 0, dig: '0, dp: '0, blank: '1, lp: 1'b1};
        m5 = m4;
        rst_n   = 1'b0;
        en      = 1'b0;
        t_dig   = '0;
        t_dp    = '0;
        t_blank = '0;
        step();
        step();
        chk("rst_an4", 32'(b4.an_o), 32'hF);
        chk("rst_seg4", 32'(b4.seg_o), 32'h7F);

        rst_n = 1'b1;
        en    = 1'b1;
        t_dig = 64'h4_3210;
        step();
        chk("first_load_an4", 32'(b4.an_o), 32'hF);
        repeat (2) step();
        chk("slot0_an4", 32'(b4.an_o), 32'hE);
        chk("slot0_seg4", 32'(b4.seg_o), 32'b1000000);
        repeat (40) step();

        for (int k = 0; k < 64 && m4.idx != 1; k++) step();
        t_dig = 64'h9_FEDC;
        repeat (80) step();

        ticks4 = 0;
        repeat (96) step();
        chk("ticks4_96", 32'(ticks4), 32'd3);

        t_blank = 16'b00100;
        t_dp    = 16'b00001;
        repeat (80) step();

        for (int k = 0; k < 64 && !(m4.idx == 1 && m4.pre == 4); k++) step();
        chk("sync_slot1", 32'(m4.idx == 1 && m4.pre == 4), 32'd1);
        en = 1'b0;
        repeat (5) step();
        chk("frz_idx4", 32'(b4.idx_o), 32'd1);
        chk("frz_an4", 32'(b4.an_o), 32'hF);
        en = 1'b1;
        repeat (48) step();

        rst_n = 1'b0;
        step();
        chk("rst2_idx4", 32'(b4.idx_o), 32'd0);
        chk("rst2_an5", 32'(b5.an_o), 32'h1F);
        rst_n = 1'b1;
        repeat (90) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
